// File: rtl/rev_pkg.sv
// Shared types and gate arithmetic for the reversible cascade engine.
// Gate indices are carried at IDX_W bits, which covers bus widths up to MAX_W wires.
package rev_pkg;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = 6;

    typedef enum logic [1:0] {
        GATE_NOP     = 2'd0,
        GATE_TOFFOLI = 2'd1,
        GATE_FREDKIN = 2'd2,
        GATE_PERES   = 2'd3
    } gate_type_e;

    typedef struct packed {
        gate_type_e       typ;
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
        logic [IDX_W-1:0] c;
    } gate_t;

    localparam gate_t GATE_NONE = '{typ: GATE_NOP, a: '0, b: '0, c: '0};

    // A gate with aliased or out-of-range wires degenerates to NOP.
    function automatic logic gate_ok(input gate_t g, input int unsigned width);
        return (g.a != g.b) && (g.a != g.c) && (g.b != g.c) &&
               (32'(g.a) < width) && (32'(g.b) < width) && (32'(g.c) < width);
    endfunction

    function automatic logic [MAX_W-1:0] apply_gate(input logic [MAX_W-1:0] w,
                                                    input gate_t g,
                                                    input int unsigned width = MAX_W);
        logic [MAX_W-1:0] r;
        logic va, vb, vc;
        r  = w;
        va = w[g.a];
        vb = w[g.b];
        vc = w[g.c];
        if (gate_ok(g, width)) begin
            case (g.typ)
                GATE_TOFFOLI: r[g.c] = vc ^ (va & vb);
                GATE_FREDKIN: begin
                    if (va) begin
                        r[g.b] = vc;
                        r[g.c] = vb;
                    end
                end
                GATE_PERES: begin
                    r[g.b] = va ^ vb;
                    r[g.c] = (va & vb) ^ vc;
                end
                default: r = w;
            endcase
        end
        return r;
    endfunction

    // Toffoli and Fredkin are self-inverse; Peres undoes B first, then C using restored B.
    function automatic logic [MAX_W-1:0] apply_gate_inv(input logic [MAX_W-1:0] w,
                                                        input gate_t g,
                                                        input int unsigned width = MAX_W);
        logic [MAX_W-1:0] r;
        logic va, nb;
        r = apply_gate(w, g, width);
        if (gate_ok(g, width) && (g.typ == GATE_PERES)) begin
            r      = w;
            va     = w[g.a];
            nb     = va ^ w[g.b];
            r[g.b] = nb;
            r[g.c] = w[g.c] ^ (va & nb);
        end
        return r;
    endfunction

endpackage

// File: rtl/rev_gate_stage.sv
// One registered cascade stage: applies its forward gate or the inverse of its
// mirrored gate according to the beat's direction, and holds on global stall.
module rev_gate_stage
    import rev_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hold,
    input  logic             i_valid,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_data,
    input  gate_t            i_gate_fwd,
    input  gate_t            i_gate_rev,
    output logic             o_valid,
    output logic             o_dir,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic             r_dir;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_rev;

    assign w_fwd = WIDTH'(apply_gate(MAX_W'(i_data), i_gate_fwd, WIDTH));
    assign w_rev = WIDTH'(apply_gate_inv(MAX_W'(i_data), i_gate_rev, WIDTH));

    // Capture the gated beat with its direction and valid unless the pipeline is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_dir   <= 1'b0;
            r_data  <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_dir   <= i_dir;
            r_data  <= i_dir ? w_rev : w_fwd;
        end
    end

    assign o_valid = r_valid;
    assign o_dir   = r_dir;
    assign o_data  = r_data;

endmodule

// File: rtl/rev_cascade_engine.sv
// Pipelined programmable cascade of reversible gates, one stage per program slot,
// followed by an output register. Optional: REV_CASCADE_XFER_COUNT_EN adds the
// saturating xfer_count output.
module rev_cascade_engine
    import rev_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IW    = $clog2(WIDTH),
    localparam int unsigned CI_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CI_W-1:0]   cfg_idx,
    input  logic [2+3*IW-1:0] cfg_gate,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dir,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef REV_CASCADE_XFER_COUNT_EN
    ,
    output logic [15:0]       xfer_count
`endif
);

    gate_t            r_prog [DEPTH];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             w_stall;
    gate_t            w_cfg;
    logic [DEPTH:0]   w_v;
    logic [DEPTH:0]   w_d;
    logic [WIDTH-1:0] w_data [0:DEPTH];
    logic             w_unused_dir;

    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign cfg_ready = ~(|w_v[DEPTH:1]) & ~in_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Narrow wire indices from the config bus are zero-extended to the package width.
    assign w_cfg.typ = gate_type_e'(cfg_gate[2+3*IW-1 -: 2]);
    assign w_cfg.a   = IDX_W'(cfg_gate[3*IW-1 -: IW]);
    assign w_cfg.b   = IDX_W'(cfg_gate[2*IW-1 -: IW]);
    assign w_cfg.c   = IDX_W'(cfg_gate[IW-1 -: IW]);

    assign w_v[0]    = in_valid;
    assign w_d[0]    = in_dir;
    assign w_data[0] = in_data;

    // Direction of a beat leaving the last stage has no further use.
    assign w_unused_dir = w_d[DEPTH];

    // Gate program: writes land only when the pipeline is empty and no beat is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_prog[i] <= GATE_NONE;
            end
        end else if (cfg_we && cfg_ready && (32'(cfg_idx) < DEPTH)) begin
            r_prog[cfg_idx] <= w_cfg;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        rev_gate_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_hold     (w_stall),
            .i_valid    (w_v[k]),
            .i_dir      (w_d[k]),
            .i_data     (w_data[k]),
            .i_gate_fwd (r_prog[k]),
            .i_gate_rev (r_prog[DEPTH-1-k]),
            .o_valid    (w_v[k+1]),
            .o_dir      (w_d[k+1]),
            .o_data     (w_data[k+1])
        );
    end

    // Output register, frozen while the sink refuses a presented result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_v[DEPTH];
            r_out_data  <= w_data[DEPTH];
        end
    end

`ifdef REV_CASCADE_XFER_COUNT_EN
    logic [15:0] r_xfer_count;

    // Saturating count of completed output transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (r_out_valid && out_ready && (r_xfer_count != 16'hFFFF)) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_rev_cascade_engine.sv
// Scoreboard bench for rev_cascade_engine (WIDTH=8, DEPTH=4).
`timescale 1ns/1ps
module tb_rev_cascade_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [1:0] T_NOP = 2'd0, T_TOF = 2'd1, T_FRE = 2'd2, T_PER = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_gate;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic        in_dir;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
`ifdef REV_CASCADE_XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    rev_cascade_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_gate  (cfg_gate),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef REV_CASCADE_XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: at the negedge the values seen are those the next edge will transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_data);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                check("out_data", 32'(out_data), 32'(mon_e.data));
                if (mon_e.cyc >= 0) check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat; timed beats also carry the cycle the result must appear.
    task automatic send(input logic [7:0] d, input logic dir, input logic [7:0] exp, input logic timed);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_dir   = dir;
        in_data  = d;
        #0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%0h", d);
        end
        sb.push_back('{data: exp, cyc: timed ? (cyc + 1 + DEPTH) : -1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, 0 required", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [1:0] typ,
                              input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_gate = {typ, a, b, c};
        #0;
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    function automatic logic [7:0] peres012(input logic [7:0] x);
        logic [7:0] r;
        r    = x;
        r[1] = x[0] ^ x[1];
        r[2] = (x[0] & x[1]) ^ x[2];
        return r;
    endfunction

    logic [7:0] casc_in  [4] = '{8'h1D, 8'hB5, 8'h7C, 8'hFF};
    logic [7:0] casc_out [4] = '{8'h1B, 8'h33, 8'h64, 8'hA6};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_gate  = '0;
        in_valid  = 1'b0;
        in_dir    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Empty program passes data through.
        send(8'h03, 1'b0, 8'h03, 1'b1);
        drain();

        // Toffoli on wires 0,1,2.
        write_slot(2'd0, T_TOF, 3'd0, 3'd1, 3'd2);
        send(8'h03, 1'b0, 8'h07, 1'b1);
        send(8'h01, 1'b0, 8'h01, 1'b1);
        drain();

        // Peres on wires 0,1,2, then full forward and reverse sweeps.
        write_slot(2'd0, T_PER, 3'd0, 3'd1, 3'd2);
        send(8'h03, 1'b0, 8'h05, 1'b1);
        send(8'h05, 1'b1, 8'h03, 1'b1);
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0, peres012(8'(i)), 1'b1);
        for (int i = 0; i < 256; i++) send(peres012(8'(i)), 1'b1, 8'(i), 1'b1);
        drain();

        // Four-gate cascade, alternating directions back to back.
        write_slot(2'd0, T_FRE, 3'd0, 3'd1, 3'd2);
        write_slot(2'd1, T_PER, 3'd2, 3'd3, 3'd4);
        write_slot(2'd2, T_TOF, 3'd4, 3'd5, 3'd7);
        write_slot(2'd3, T_PER, 3'd7, 3'd6, 3'd0);
        for (int i = 0; i < 4; i++) begin
            send(casc_in[i], 1'b0, casc_out[i], 1'b1);
            send(casc_out[i], 1'b1, casc_in[i], 1'b1);
        end
        drain();

        // Sink stall of three cycles with results queued behind.
        p0 = pops;
        send(8'h1D, 1'b0, 8'h1B, 1'b0);
        send(8'hB5, 1'b0, 8'h33, 1'b0);
        send(8'h7C, 1'b0, 8'h64, 1'b0);
        wait_out_valid();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'h1B);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        drain();
        check("stall_result_count", 32'(pops - p0), 32'd3);

        // Program writes refused while a beat is in flight or offered.
        write_slot(2'd0, T_TOF, 3'd0, 3'd1, 3'd2);
        write_slot(2'd1, T_NOP, 3'd0, 3'd0, 3'd0);
        write_slot(2'd2, T_NOP, 3'd0, 3'd0, 3'd0);
        write_slot(2'd3, T_NOP, 3'd0, 3'd0, 3'd0);
        send(8'h03, 1'b0, 8'h07, 1'b1);
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_gate = {T_NOP, 3'd0, 3'd0, 3'd0};
        #0;
        check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
        tick();
        cfg_we = 1'b0;
        drain();
        send(8'h03, 1'b0, 8'h07, 1'b1);
        drain();
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_gate = {T_NOP, 3'd0, 3'd0, 3'd0};
        send(8'h03, 1'b0, 8'h07, 1'b1);
        cfg_we = 1'b0;
        drain();
        send(8'h03, 1'b0, 8'h07, 1'b1);
        drain();

        // Asynchronous reset in the middle of a stream.
        send(8'h03, 1'b0, 8'h07, 1'b0);
        send(8'h01, 1'b0, 8'h01, 1'b0);
        send(8'h07, 1'b0, 8'h03, 1'b0);
        send(8'h00, 1'b0, 8'h00, 1'b0);
        send(8'h05, 1'b0, 8'h05, 1'b0);
        wait_out_valid();
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", 32'(out_data), 32'd0);
        check("midreset_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef REV_CASCADE_XFER_COUNT_EN
        check("midreset_xfer_count", 32'(xfer_count), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h03, 1'b0, 8'h03, 1'b1);
        send(8'h03, 1'b1, 8'h03, 1'b1);
        drain();
`ifdef REV_CASCADE_XFER_COUNT_EN
        check("xfer_count_after_reset", 32'(xfer_count), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
